// File: rtl/mipi_csi_rx_packet_handler.sv
// CSI-2 RX packet handler: parses packet headers, raises sync strobes for short
// packets and forwards the word-count payload bytes of selected long packets.
module mipi_csi_rx_packet_handler (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [2:0]      active_lanes_i,
  input  logic [1:0]      vc_filter_i,
  input  logic [3:0][7:0] lane_data_i,
  input  logic [3:0]      lane_valid_i,
  output logic [3:0][7:0] payload_data_o,
  output logic [3:0]      payload_valid_o,
  output logic [5:0]      data_type_o,
  output logic [15:0]     word_count_o,
  output logic            frame_start_o,
  output logic            frame_end_o,
  output logic            line_start_o,
  output logic            line_end_o,
  output logic            line_active_o,
  output logic            err_truncated_o
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CRC, DISCARD} state_e;

  state_e          state_q;
  logic [2:0]      lanes_q, lanes_d;
  logic [2:0]      hcnt_q, hbase, hsum;
  logic [3:0][7:0] hdr_q, hdr_d;
  logic [15:0]     remaining_q;
  logic [1:0]      crc_q;
  logic [2:0]      nvld, fwd, extra, crc_sum;
  logic [3:0]      fwd_mask;
  logic [3:0][7:0] fwd_data;
  logic            any_vld, hdr_done;
  logic [1:0]      hdr_vc;
  logic [5:0]      hdr_dt;
  logic [15:0]     hdr_wc;

  assign any_vld = |lane_valid_i;

  always_comb begin
    lanes_d = lanes_q;
    if (state_q == IDLE)
      lanes_d = (active_lanes_i == 3'd2 || active_lanes_i == 3'd4) ? active_lanes_i : 3'd1;
  end

  // Bytes arrive lane 3 first; each valid active lane fills the next header slot.
  always_comb begin
    hbase = (state_q == IDLE) ? 3'd0 : hcnt_q;
    nvld  = '0;
    hdr_d = hdr_q;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(lanes_d) && lane_valid_i[3-k]) begin
        nvld = nvld + 3'd1;
        hdr_d[hbase[1:0] + 2'(k)] = lane_data_i[3-k];
      end
    end
  end

  assign hsum     = hbase + nvld;
  assign hdr_done = hsum[2];
  assign hdr_vc   = hdr_d[0][7:6];
  assign hdr_dt   = hdr_d[0][5:0];
  assign hdr_wc   = {hdr_d[2], hdr_d[1]};

  // Forward the leading min(N, remaining) lanes; anything behind them is CRC.
  always_comb begin
    fwd      = (remaining_q < 16'(lanes_q)) ? remaining_q[2:0] : lanes_q;
    extra    = (nvld > fwd) ? nvld - fwd : 3'd0;
    crc_sum  = {1'b0, crc_q} + nvld;
    fwd_mask = '0;
    fwd_data = '0;
    for (int k = 0; k < 4; k++)
      fwd_mask[3-k] = (k < int'(fwd)) && lane_valid_i[3-k];
    for (int k = 0; k < 4; k++)
      fwd_data[k] = fwd_mask[k] ? lane_data_i[k] : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      lanes_q         <= 3'd1;
      hcnt_q          <= '0;
      hdr_q           <= '0;
      remaining_q     <= '0;
      crc_q           <= '0;
      payload_data_o  <= '0;
      payload_valid_o <= '0;
      data_type_o     <= '0;
      word_count_o    <= '0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      line_active_o   <= 1'b0;
      err_truncated_o <= 1'b0;
    end else begin
      payload_data_o  <= '0;
      payload_valid_o <= '0;
      line_active_o   <= 1'b0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      err_truncated_o <= 1'b0;
      lanes_q         <= lanes_d;
      case (state_q)
        IDLE, HEADER: begin
          if (!any_vld) begin
            hcnt_q <= '0;
            if (state_q == HEADER) begin
              err_truncated_o <= 1'b1;
              state_q         <= IDLE;
            end
          end else begin
            hdr_q  <= hdr_d;
            hcnt_q <= hsum;
            if (!hdr_done) begin
              state_q <= HEADER;
            end else if (hdr_dt < 6'h10) begin
              frame_start_o <= (hdr_dt == 6'h00);
              frame_end_o   <= (hdr_dt == 6'h01);
              line_start_o  <= (hdr_dt == 6'h02);
              line_end_o    <= (hdr_dt == 6'h03);
              state_q       <= DISCARD;
            end else if (hdr_vc != vc_filter_i) begin
              state_q <= DISCARD;
            end else begin
              data_type_o  <= hdr_dt;
              word_count_o <= hdr_wc;
              remaining_q  <= hdr_wc;
              crc_q        <= '0;
              state_q      <= (hdr_wc == 16'd0) ? CRC : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (!any_vld) begin
            err_truncated_o <= 1'b1;
            state_q         <= IDLE;
          end else begin
            payload_valid_o <= fwd_mask;
            payload_data_o  <= fwd_data;
            line_active_o   <= |fwd_mask;
            remaining_q     <= remaining_q - 16'(fwd);
            if (remaining_q == 16'(fwd)) begin
              if (extra >= 3'd2) begin
                state_q <= DISCARD;
              end else begin
                crc_q   <= extra[1:0];
                state_q <= CRC;
              end
            end
          end
        end
        CRC: begin
          if (!any_vld) begin
            err_truncated_o <= 1'b1;
            state_q         <= IDLE;
          end else if (crc_sum >= 3'd2) begin
            state_q <= DISCARD;
          end else begin
            crc_q <= crc_sum[1:0];
          end
        end
        DISCARD: if (!any_vld) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_packet_handler.sv
// Directed and randomized packet bench; expectations come from byte-position
// rules over each packet's byte stream.
module tb_mipi_csi_rx_packet_handler;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [2:0]      active_lanes_i;
  logic [1:0]      vc_filter_i;
  logic [3:0][7:0] lane_data_i;
  logic [3:0]      lane_valid_i;
  logic [3:0][7:0] payload_data_o;
  logic [3:0]      payload_valid_o;
  logic [5:0]      data_type_o;
  logic [15:0]     word_count_o;
  logic            frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic            line_active_o, err_truncated_o;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] m_dt;
  logic [15:0] m_wc;
  logic [5:0] rdt;
  logic [1:0] rvc;
  int         sel, trunc;

  always #5 clk = ~clk;

  mipi_csi_rx_packet_handler dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .active_lanes_i (active_lanes_i),
    .vc_filter_i    (vc_filter_i),
    .lane_data_i    (lane_data_i),
    .lane_valid_i   (lane_valid_i),
    .payload_data_o (payload_data_o),
    .payload_valid_o(payload_valid_o),
    .data_type_o    (data_type_o),
    .word_count_o   (word_count_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .line_start_o   (line_start_o),
    .line_end_o     (line_end_o),
    .line_active_o  (line_active_o),
    .err_truncated_o(err_truncated_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [3:0] e_pv, input logic [3:0][7:0] e_pd,
                               input logic [3:0][7:0] mask, input logic [3:0] e_sync,
                               input logic e_err);
    check("payload_valid", 32'(payload_valid_o), 32'(e_pv));
    check("payload_data", 32'(payload_data_o & mask), 32'(e_pd));
    check("line_active", 32'(line_active_o), 32'(|e_pv));
    check("sync", 32'({frame_start_o, frame_end_o, line_start_o, line_end_o}), 32'(e_sync));
    check("err_truncated", 32'(err_truncated_o), 32'(e_err));
    check("data_type", 32'(data_type_o), 32'(m_dt));
    check("word_count", 32'(word_count_o), 32'(m_wc));
  endtask

  // Send one packet (header, plus payload and CRC for long DTs), cut after
  // 'trunc' cycles, optionally reset in cycle rst_at, then two idle cycles.
  task automatic send_pkt(input logic [2:0] cfg, input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input int trunc, input int rst_at);
    logic [7:0]      bytes[$];
    int              n, nb, c, k_cyc, hc, lim, b;
    bit              acc;
    logic [3:0]      e_pv, e_sync;
    logic [3:0][7:0] e_pd, mask;
    logic            e_err;
    n   = (cfg == 3'd2 || cfg == 3'd4) ? int'(cfg) : 1;
    acc = (dt >= 6'h10) && (vc == vc_filter_i);
    bytes.push_back({vc, dt});
    bytes.push_back(wc[7:0]);
    bytes.push_back(wc[15:8]);
    bytes.push_back(8'($urandom));
    if (dt >= 6'h10)
      for (int i = 0; i < int'(wc) + 2; i++) bytes.push_back(8'($urandom));
    nb    = bytes.size();
    c     = (nb + n - 1) / n;
    k_cyc = (trunc < c) ? trunc : c;
    if (rst_at >= 0 && rst_at + 1 < k_cyc) k_cyc = rst_at + 1;
    hc    = 4 / n - 1;
    lim   = acc ? int'(wc) + 6 : 4;
    for (int j = 0; j < k_cyc + 2; j++) begin
      active_lanes_i = (j == 0) ? cfg : 3'($urandom);
      lane_valid_i   = '0;
      lane_data_i    = $urandom;
      e_pv = '0; e_pd = '0; mask = '0;
      for (int k = 0; k < n; k++) begin
        b = j * n + k;
        if (j < k_cyc && b < nb) begin
          lane_valid_i[3-k] = 1'b1;
          lane_data_i[3-k]  = bytes[b];
          if (acc && b >= 4 && b < 4 + int'(wc)) begin
            e_pv[3-k] = 1'b1;
            e_pd[3-k] = bytes[b];
            mask[3-k] = 8'hFF;
          end
        end
      end
      e_sync = (j == hc && k_cyc > hc && dt < 6'h04) ? (4'b1000 >> dt) : 4'b0000;
      e_err  = (j == k_cyc) && (k_cyc * n < lim);
      if (j == hc && k_cyc > hc && acc) begin
        m_dt = dt;
        m_wc = wc;
      end
      reset_i = (j == rst_at);
      if (rst_at >= 0 && j >= rst_at) begin
        e_pv = '0; e_pd = '0; mask = '0; e_sync = '0; e_err = 1'b0;
      end
      if (j == rst_at) begin
        m_dt = '0;
        m_wc = '0;
      end
      @(negedge clk);
      check_outputs(e_pv, e_pd, mask, e_sync, e_err);
    end
    reset_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i        = 1'b1;
    active_lanes_i = 3'd4;
    vc_filter_i    = 2'd0;
    lane_valid_i   = 4'hF;
    lane_data_i    = $urandom;
    m_dt           = '0;
    m_wc           = '0;
    repeat (3) @(negedge clk);
    check_outputs(4'h0, '0, '0, 4'h0, 1'b0);
    reset_i      = 1'b0;
    lane_valid_i = '0;
    @(negedge clk);

    send_pkt(3'd4, 2'd0, 6'h00, 16'd0, 1000, -1);   // frame start
    send_pkt(3'd4, 2'd0, 6'h2A, 16'd6, 1000, -1);   // RAW8, 6 bytes
    send_pkt(3'd2, 2'd0, 6'h22, 16'd4, 1000, -1);   // RGB565 on 2 lanes
    send_pkt(3'd1, 2'd1, 6'h2A, 16'd5, 1000, -1);   // filtered VC
    send_pkt(3'd4, 2'd0, 6'h2A, 16'd8, 2, -1);      // truncated payload
    send_pkt(3'd4, 2'd0, 6'h00, 16'd0, 1000, -1);
    send_pkt(3'd4, 2'd0, 6'h2B, 16'd8, 1000, 2);    // reset in 2nd payload cycle
    send_pkt(3'd4, 2'd0, 6'h24, 16'd3, 1000, -1);
    send_pkt(3'd2, 2'd2, 6'h01, 16'd0, 1000, -1);   // frame end
    send_pkt(3'd2, 2'd0, 6'h02, 16'd0, 1000, -1);   // line start
    send_pkt(3'd1, 2'd3, 6'h03, 16'd0, 1000, -1);   // line end
    send_pkt(3'd1, 2'd0, 6'h07, 16'd0, 1000, -1);   // reserved short
    send_pkt(3'd1, 2'd0, 6'h00, 16'd0, 2, -1);      // truncated header
    send_pkt(3'd3, 2'd0, 6'h2A, 16'd3, 1000, -1);   // illegal lane count -> 1
    send_pkt(3'd4, 2'd0, 6'h2A, 16'd0, 1000, -1);   // empty long packet
    send_pkt(3'd1, 2'd0, 6'h2A, 16'd0, 5, -1);      // truncated in CRC

    for (int p = 0; p < 60; p++) begin
      sel = int'($urandom_range(0, 3));
      rdt = (sel == 0) ? 6'($urandom_range(0, 3)) :
            (sel == 1) ? 6'($urandom_range(4, 15)) : 6'($urandom_range(16, 63));
      vc_filter_i = 2'($urandom);
      rvc   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : vc_filter_i;
      trunc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 1000;
      send_pkt(3'($urandom), rvc, rdt, 16'($urandom_range(0, 20)), trunc, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
